// File: rtl/tt_response_checker.sv
// Truth-table checker: drives every stim vector, samples c after SETTLE cycles, compares against EXPECT.
// Optional macro TT_RESPONSE_CHECKER_STOP_ON_FAIL_EN ends a run on its first mismatch.
module tt_response_checker #(
    parameter int                  N_IN   = 2,
    parameter int                  SETTLE = 4,
    parameter logic [2**N_IN-1:0]  EXPECT = 4'b1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [N_IN-1:0]      stim,
    input  logic                 c,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_fail,
    output logic [2**N_IN-1:0]   resp
);
    localparam int NV = 2**N_IN;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [N_IN-1:0] vec;
    logic            c_q;
    logic            miss;
    logic            last;

    // c is registered on the edge that ends the settle window; SAMPLE judges that captured value,
    // so stim has been stable for exactly SETTLE cycles before the sample edge.
    assign miss = (c_q != EXPECT[vec]);
    assign last = (vec == N_IN'(NV - 1));
    assign stim = vec;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            vec        <= '0;
            c_q        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            resp       <= '0;
        end else begin
            c_q <= c;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        first_fail <= '0;
                        resp       <= '0;
                        vec        <= '0;
                        busy       <= 1'b1;
                        cnt        <= CW'(SETTLE - 1);
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        state <= S_SAMPLE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_SAMPLE: begin
                    resp[vec] <= c_q;
                    if (miss) begin
                        err_count <= err_count + (N_IN+1)'(1);
                        if (err_count == '0) begin
                            first_fail <= vec;
                        end
                    end
`ifdef TT_RESPONSE_CHECKER_STOP_ON_FAIL_EN
                    if (last || miss) begin
`else
                    if (last) begin
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == '0) && !miss;
                        state <= S_IDLE;
                    end else begin
                        vec   <= vec + N_IN'(1);
                        cnt   <= CW'(SETTLE - 1);
                        state <= S_SETTLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
